// File: rtl/sram_axi_bridge_pkg.sv
// Shared definitions for the SRAM-like to AXI3 bridge: FSM state codes,
// fixed AXI attribute values and the size-to-byte-strobe mapping.
package sram_axi_bridge_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RADDR = 3'd1;
    localparam logic [2:0] ST_RDATA = 3'd2;
    localparam logic [2:0] ST_WADDR = 3'd3;
    localparam logic [2:0] ST_WRESP = 3'd4;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [3:0] ID_INST    = 4'd0;
    localparam logic [3:0] ID_DATA    = 4'd1;
    localparam logic [3:0] LEN_SINGLE = 4'd0;
    localparam logic [1:0] SIZE_WORD  = 2'd2;

    // Lane enables for a naturally aligned access; sizes above half map to a full word.
    function automatic logic [3:0] size_to_wstrb(input logic [1:0] size,
                                                 input logic [1:0] offset);
        logic [3:0] strb;
        case (size)
            2'd0:    strb = 4'b0001 << offset;
            2'd1:    strb = offset[1] ? 4'b1100 : 4'b0011;
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/sram_axi_bridge_if.sv
// 32-bit AXI3 bus between the bridge (master) and the interconnect (slave).
interface sram_axi_bridge_if;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;

    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;

    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/sram_axi_bridge.sv
// Serialises the instruction and data SRAM-like ports onto one AXI3 master,
// keeping at most one transaction in flight.
module sram_axi_bridge
    import sram_axi_bridge_pkg::*;
#(
    parameter bit DATA_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    sram_axi_bridge_if.master axi
);

    logic [2:0]  state_q, state_d;
    logic        src_data_q;
    logic        wr_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;

    logic        idle;
    logic        pick_data;
    logic        pick_inst;
    logic        grant;
    logic        req_wr;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_done;

    // Grants are only issued from IDLE and are suppressed while reset is held.
    assign idle      = (state_q == ST_IDLE) && !rst;
    assign pick_data = data_req && (DATA_FIRST || !inst_req);
    assign pick_inst = inst_req && (!DATA_FIRST || !data_req);
    assign grant     = idle && (pick_data || pick_inst);

    assign inst_addr_ok = idle && pick_inst;
    assign data_addr_ok = idle && pick_data;

    assign req_wr    = pick_data ? data_wr    : inst_wr;
    assign req_size  = pick_data ? data_size  : inst_size;
    assign req_addr  = pick_data ? data_addr  : inst_addr;
    assign req_wdata = pick_data ? data_wdata : inst_wdata;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            ST_IDLE: begin
                if (grant) state_d = req_wr ? ST_WADDR : ST_RADDR;
            end
            ST_RADDR: begin
                if (axi.arready) state_d = ST_RDATA;
            end
            ST_RDATA: begin
                if (axi.rvalid) state_d = ST_IDLE;
            end
            ST_WADDR: begin
                // Each channel retires independently; both may finish on the same edge.
                aw_done_d = aw_done_q | axi.awready;
                w_done_d  = w_done_q  | axi.wready;
                if (aw_done_d && w_done_d) begin
                    state_d   = ST_WRESP;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            ST_WRESP: begin
                if (axi.bvalid) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            src_data_q <= 1'b0;
            wr_q       <= 1'b0;
            size_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            if (grant) begin
                src_data_q <= pick_data;
                wr_q       <= req_wr;
                size_q     <= (req_size == 2'd3) ? SIZE_WORD : req_size;
                addr_q     <= req_addr;
                wdata_q    <= req_wdata;
            end
        end
    end

    assign rsp_done = ((state_q == ST_RDATA) && axi.rvalid) ||
                      ((state_q == ST_WRESP) && axi.bvalid);

    assign inst_data_ok = rsp_done && !src_data_q;
    assign data_data_ok = rsp_done &&  src_data_q;
    assign inst_rdata   = axi.rdata;
    assign data_rdata   = axi.rdata;

    assign axi.arid    = src_data_q ? ID_DATA : ID_INST;
    assign axi.araddr  = addr_q;
    assign axi.arlen   = LEN_SINGLE;
    assign axi.arsize  = {1'b0, size_q};
    assign axi.arburst = BURST_INCR;
    assign axi.arlock  = 2'b00;
    assign axi.arcache = 4'b0000;
    assign axi.arprot  = 3'b000;
    assign axi.arvalid = (state_q == ST_RADDR);
    assign axi.rready  = (state_q == ST_RDATA);

    assign axi.awid    = ID_DATA;
    assign axi.awaddr  = addr_q;
    assign axi.awlen   = LEN_SINGLE;
    assign axi.awsize  = {1'b0, size_q};
    assign axi.awburst = BURST_INCR;
    assign axi.awlock  = 2'b00;
    assign axi.awcache = 4'b0000;
    assign axi.awprot  = 3'b000;
    assign axi.awvalid = (state_q == ST_WADDR) && !aw_done_q;

    assign axi.wid     = ID_DATA;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = size_to_wstrb(size_q, addr_q[1:0]);
    assign axi.wlast   = 1'b1;
    assign axi.wvalid  = (state_q == ST_WADDR) && !w_done_q;
    assign axi.bready  = (state_q == ST_WRESP);

    // Responses are always treated as OKAY; wr_q is kept for completeness of the latched request.
    logic unused_inputs;
    assign unused_inputs = ^{axi.rresp, axi.bresp, wr_q};

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed and randomized bench for sram_axi_bridge against a transaction-level model.
module tb_sram_axi_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sram_axi_bridge_if axi_bus ();

    sram_axi_bridge #(.DATA_FIRST(1'b1)) dut (
        .clk         (clk),
        .rst         (rst),
        .inst_req    (inst_req),
        .inst_wr     (inst_wr),
        .inst_size   (inst_size),
        .inst_addr   (inst_addr),
        .inst_wdata  (inst_wdata),
        .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok),
        .inst_rdata  (inst_rdata),
        .data_req    (data_req),
        .data_wr     (data_wr),
        .data_size   (data_size),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok),
        .data_rdata  (data_rdata),
        .axi         (axi_bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Byte lanes covered by an aligned access of 2**size bytes (size 3 counts as a word).
    function automatic logic [3:0] exp_strb(input logic [1:0] sz, input logic [31:0] a);
        int n;
        int base;
        n    = (sz == 2'd3) ? 4 : (1 << sz);
        base = int'(a[1:0]) & ~(n - 1);
        return 4'(((1 << n) - 1) << base);
    endfunction

    // Transaction model: which AXI phases of the single outstanding request are still pending.
    bit          m_busy, m_src_data, m_ar, m_r, m_aw, m_w, m_b;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata;

    always @(negedge clk) begin
        bit gd, gi, done, wr;
        if (rst) begin
            check("rst_inst_addr_ok", inst_addr_ok, 0);
            check("rst_data_addr_ok", data_addr_ok, 0);
            check("rst_inst_data_ok", inst_data_ok, 0);
            check("rst_data_data_ok", data_data_ok, 0);
            check("rst_arvalid", axi_bus.arvalid, 0);
            check("rst_rready", axi_bus.rready, 0);
            check("rst_awvalid", axi_bus.awvalid, 0);
            check("rst_wvalid", axi_bus.wvalid, 0);
            check("rst_bready", axi_bus.bready, 0);
            {m_busy, m_src_data, m_ar, m_r, m_aw, m_w, m_b} = '0;
        end else begin
            gd   = !m_busy && data_req;
            gi   = !m_busy && inst_req && !data_req;
            done = (m_r && axi_bus.rvalid) || (m_b && axi_bus.bvalid);
            check("m_inst_addr_ok", inst_addr_ok, gi);
            check("m_data_addr_ok", data_addr_ok, gd);
            check("m_inst_data_ok", inst_data_ok, done && !m_src_data);
            check("m_data_data_ok", data_data_ok, done && m_src_data);
            check("m_inst_rdata", inst_rdata, axi_bus.rdata);
            check("m_data_rdata", data_rdata, axi_bus.rdata);
            check("m_arvalid", axi_bus.arvalid, m_ar);
            check("m_rready", axi_bus.rready, m_r);
            check("m_awvalid", axi_bus.awvalid, m_aw);
            check("m_wvalid", axi_bus.wvalid, m_w);
            check("m_bready", axi_bus.bready, m_b);
            check("m_arlen", axi_bus.arlen, 0);
            check("m_arburst", axi_bus.arburst, 1);
            check("m_awid", axi_bus.awid, 1);
            check("m_wlast", axi_bus.wlast, 1);
            if (m_ar) begin
                check("m_araddr", axi_bus.araddr, m_addr);
                check("m_arsize", axi_bus.arsize, {1'b0, m_size});
                check("m_arid", axi_bus.arid, m_src_data ? 1 : 0);
            end
            if (m_aw) begin
                check("m_awaddr", axi_bus.awaddr, m_addr);
                check("m_awsize", axi_bus.awsize, {1'b0, m_size});
            end
            if (m_w) begin
                check("m_wdata", axi_bus.wdata, m_wdata);
                check("m_wstrb", axi_bus.wstrb, exp_strb(m_size, m_addr));
            end
            // Advance to the state after the coming rising edge (inputs are stable until then).
            if (gd || gi) begin
                m_busy     = 1'b1;
                m_src_data = gd;
                wr         = gd ? data_wr : inst_wr;
                m_addr     = gd ? data_addr : inst_addr;
                m_wdata    = gd ? data_wdata : inst_wdata;
                m_size     = gd ? data_size : inst_size;
                if (m_size == 2'd3) m_size = 2'd2;
                m_ar = !wr;
                m_aw = wr;
                m_w  = wr;
            end else if (m_ar) begin
                if (axi_bus.arready) begin m_ar = 1'b0; m_r = 1'b1; end
            end else if (m_r) begin
                if (axi_bus.rvalid) begin m_r = 1'b0; m_busy = 1'b0; end
            end else if (m_aw || m_w) begin
                if (axi_bus.awready) m_aw = 1'b0;
                if (axi_bus.wready)  m_w  = 1'b0;
                if (!m_aw && !m_w)   m_b  = 1'b1;
            end else if (m_b && axi_bus.bvalid) begin
                m_b    = 1'b0;
                m_busy = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        inst_req = 0; inst_wr = 0; inst_size = 2; inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 2; data_addr = 0; data_wdata = 0;
        axi_bus.arready = 0; axi_bus.rvalid = 0; axi_bus.rdata = 0; axi_bus.rresp = 0;
        axi_bus.awready = 0; axi_bus.wready = 0; axi_bus.bvalid = 0; axi_bus.bresp = 0;
    endtask

    initial begin
        quiet();
        rst = 1;
        inst_req = 1;
        data_req = 1;
        @(negedge clk);
        check("reset_arvalid", axi_bus.arvalid, 0);
        check("reset_awvalid", axi_bus.awvalid, 0);
        check("reset_inst_addr_ok", inst_addr_ok, 0);
        check("reset_data_addr_ok", data_addr_ok, 0);
        step(); quiet(); rst = 0;

        // Instruction read, rvalid one cycle after the AR handshake.
        step(); inst_req = 1; inst_addr = 32'h1FC0_0000; inst_size = 2; axi_bus.arready = 1;
        @(negedge clk);
        check("t1_inst_addr_ok", inst_addr_ok, 1);
        check("t1_data_addr_ok", data_addr_ok, 0);
        step(); inst_req = 0; inst_addr = 32'hDEAD_BEEF;
        @(negedge clk);
        check("t1_arvalid", axi_bus.arvalid, 1);
        check("t1_araddr", axi_bus.araddr, 32'h1FC0_0000);
        check("t1_arsize", axi_bus.arsize, 3'd2);
        check("t1_arid", axi_bus.arid, 0);
        step(); axi_bus.arready = 0; axi_bus.rvalid = 1; axi_bus.rdata = 32'h2408_0001;
        @(negedge clk);
        check("t1_inst_data_ok", inst_data_ok, 1);
        check("t1_inst_rdata", inst_rdata, 32'h2408_0001);
        check("t1_data_data_ok", data_data_ok, 0);
        step(); axi_bus.rvalid = 0;
        @(negedge clk);
        check("t1_single_pulse", inst_data_ok, 0);

        // Data byte write to an odd address.
        step(); data_req = 1; data_wr = 1; data_size = 0;
        data_addr = 32'h8000_0001; data_wdata = 32'h0000_AB00;
        @(negedge clk);
        check("t2_data_addr_ok", data_addr_ok, 1);
        step(); data_req = 0; data_wr = 0; axi_bus.awready = 1; axi_bus.wready = 1;
        @(negedge clk);
        check("t2_awvalid", axi_bus.awvalid, 1);
        check("t2_wvalid", axi_bus.wvalid, 1);
        check("t2_awaddr", axi_bus.awaddr, 32'h8000_0001);
        check("t2_wstrb", axi_bus.wstrb, 4'b0010);
        check("t2_wdata", axi_bus.wdata, 32'h0000_AB00);
        step(); axi_bus.awready = 0; axi_bus.wready = 0; axi_bus.bvalid = 1;
        @(negedge clk);
        check("t2_bready", axi_bus.bready, 1);
        check("t2_data_data_ok", data_data_ok, 1);
        check("t2_inst_data_ok", inst_data_ok, 0);
        step(); axi_bus.bvalid = 0;

        // Simultaneous requests: data wins, instruction follows after data_ok.
        step(); inst_req = 1; inst_addr = 32'h1FC0_0010; inst_size = 2;
        data_req = 1; data_wr = 0; data_addr = 32'h8000_1000; data_size = 3; axi_bus.arready = 1;
        @(negedge clk);
        check("t3_data_addr_ok", data_addr_ok, 1);
        check("t3_inst_addr_ok", inst_addr_ok, 0);
        step(); data_req = 0;
        @(negedge clk);
        check("t3_arid_data", axi_bus.arid, 1);
        check("t3_arsize_sz3", axi_bus.arsize, 3'd2);
        check("t3_inst_wait", inst_addr_ok, 0);
        step(); axi_bus.arready = 0; axi_bus.rvalid = 1; axi_bus.rdata = 32'hCAFE_F00D;
        @(negedge clk);
        check("t3_data_data_ok", data_data_ok, 1);
        check("t3_data_rdata", data_rdata, 32'hCAFE_F00D);
        check("t3_inst_still_wait", inst_addr_ok, 0);
        step(); axi_bus.rvalid = 0; axi_bus.arready = 1;
        @(negedge clk);
        check("t3_inst_granted", inst_addr_ok, 1);
        step(); inst_req = 0;
        @(negedge clk);
        check("t3_inst_araddr", axi_bus.araddr, 32'h1FC0_0010);
        check("t3_inst_arid", axi_bus.arid, 0);
        step(); axi_bus.arready = 0; axi_bus.rvalid = 1; axi_bus.rdata = 32'h0000_1234;
        @(negedge clk);
        check("t3_inst_data_ok", inst_data_ok, 1);
        step(); axi_bus.rvalid = 0;

        // Half-word write with wready three cycles after awready.
        step(); data_req = 1; data_wr = 1; data_size = 1;
        data_addr = 32'h8000_0006; data_wdata = 32'h1234_0000;
        @(negedge clk);
        check("t4_data_addr_ok", data_addr_ok, 1);
        step(); data_req = 0; data_wr = 0; axi_bus.awready = 1;
        @(negedge clk);
        check("t4_awvalid_c1", axi_bus.awvalid, 1);
        check("t4_wvalid_c1", axi_bus.wvalid, 1);
        step(); axi_bus.awready = 0;
        @(negedge clk);
        check("t4_awvalid_c2", axi_bus.awvalid, 0);
        check("t4_wvalid_c2", axi_bus.wvalid, 1);
        check("t4_bready_c2", axi_bus.bready, 0);
        step();
        @(negedge clk);
        check("t4_wvalid_c3", axi_bus.wvalid, 1);
        check("t4_bready_c3", axi_bus.bready, 0);
        step(); axi_bus.wready = 1;
        @(negedge clk);
        check("t4_wvalid_c4", axi_bus.wvalid, 1);
        check("t4_wstrb", axi_bus.wstrb, 4'b1100);
        check("t4_bready_c4", axi_bus.bready, 0);
        step(); axi_bus.wready = 0; axi_bus.bvalid = 1;
        @(negedge clk);
        check("t4_bready_c5", axi_bus.bready, 1);
        check("t4_data_data_ok", data_data_ok, 1);
        step(); axi_bus.bvalid = 0;

        // Reset while waiting for read data, then a clean read.
        step(); inst_req = 1; inst_addr = 32'h1FC0_0020; inst_size = 2; axi_bus.arready = 1;
        step(); inst_req = 0;
        step(); axi_bus.arready = 0;
        @(negedge clk);
        check("t5_rready_before", axi_bus.rready, 1);
        step(); rst = 1; inst_req = 1; data_req = 1; axi_bus.rvalid = 1;
        #1;
        check("t5_rready_rst", axi_bus.rready, 0);
        check("t5_arvalid_rst", axi_bus.arvalid, 0);
        check("t5_inst_data_ok_rst", inst_data_ok, 0);
        check("t5_inst_addr_ok_rst", inst_addr_ok, 0);
        check("t5_data_addr_ok_rst", data_addr_ok, 0);
        step(); rst = 0; quiet();
        step(); inst_req = 1; inst_addr = 32'h1FC0_0040; inst_size = 2; axi_bus.arready = 1;
        @(negedge clk);
        check("t5_regrant", inst_addr_ok, 1);
        step(); inst_req = 0;
        step(); axi_bus.arready = 0; axi_bus.rvalid = 1; axi_bus.rdata = 32'h8C08_0004;
        @(negedge clk);
        check("t5_inst_data_ok", inst_data_ok, 1);
        check("t5_inst_rdata", inst_rdata, 32'h8C08_0004);
        step(); quiet();

        // Randomized traffic checked by the model every cycle.
        for (int i = 0; i < 4000; i++) begin
            step();
            inst_req   = 1'($urandom_range(0, 1));
            inst_size  = 2'($urandom_range(0, 3));
            inst_addr  = $urandom;
            inst_wdata = $urandom;
            data_req   = 1'($urandom_range(0, 1));
            data_wr    = 1'($urandom_range(0, 1));
            data_size  = 2'($urandom_range(0, 3));
            data_addr  = $urandom;
            data_wdata = $urandom;
            axi_bus.arready = ($urandom_range(0, 9) < 6);
            axi_bus.awready = ($urandom_range(0, 9) < 6);
            axi_bus.wready  = ($urandom_range(0, 9) < 5);
            axi_bus.rvalid  = 1'($urandom_range(0, 1));
            axi_bus.bvalid  = 1'($urandom_range(0, 1));
            axi_bus.rdata   = $urandom;
            axi_bus.rresp   = 2'($urandom_range(0, 3));
            axi_bus.bresp   = 2'($urandom_range(0, 3));
            rst = ($urandom_range(0, 299) == 0);
        end
        step(); quiet(); rst = 0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
